// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: 8086-mode INTA agent placed after the 8259A PIC.
// Synchronizes INT, drives two INTA pulses, then hands the captured vector
// to the core over a valid/ready handshake and counts the handshakes.
// Ports:
//   clock, reset            - single clock, synchronous active-high reset
//   interrupt_enable        - CPU IF flag, gates only the start of a sequence
//   interrupt_to_cpu        - asynchronous INT from the PIC
//   interrupt_acknowledge_n - registered, active-low INTA to the PIC
//   pic_data_bus(_io)       - PIC data bus and direction (0 = PIC driving)
//   vector/_valid/_ready    - captured vector handshake toward the core
//   vector_error            - PIC was not driving the bus at capture
//   ack_count               - completed handshakes, wraps at 2^16
module pic_inta_sequencer #(
    parameter int PULSE_WIDTH = 2,
    parameter int GAP         = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       interrupt_enable,
    input  logic       interrupt_to_cpu,
    output logic       interrupt_acknowledge_n,
    input  logic [7:0] pic_data_bus,
    input  logic       pic_data_bus_io,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ready,
    output logic       vector_error,
    output logic [15:0] ack_count
);

    // RECOVER lasts two extra cycles so a released INT has time to
    // drain through the synchronizer before IDLE looks at it again.
    localparam int RECOVER_LEN = GAP + 2;
    localparam int MAX_LEN =
        (PULSE_WIDTH > RECOVER_LEN) ? PULSE_WIDTH : RECOVER_LEN;
    localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // The counter holds "cycles remaining minus one" in each phase.
    localparam logic [CW-1:0] PW_LOAD  = CW'(PULSE_WIDTH - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);
    localparam logic [CW-1:0] REC_LOAD = CW'(RECOVER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACK1,
        GAP1,
        ACK2,
        HOLD,
        RECOVER
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          inta_n_q, inta_n_d;
    logic          valid_q, valid_d;
    logic [7:0]    vector_q, vector_d;
    logic          error_q, error_d;
    logic [15:0]   ack_count_q, ack_count_d;

    logic cnt_last;
    logic accept;

    always_comb begin
        sync1_d     = interrupt_to_cpu;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        vector_d    = vector_q;
        error_d     = error_q;
        ack_count_d = ack_count_q;
        cnt_last    = (cnt_q == '0);
        accept      = valid_q & vector_ready;

        unique case (state_q)
            IDLE: begin
                if (sync2_q && interrupt_enable) begin
                    state_d = ACK1;
                    cnt_d   = PW_LOAD;
                end
            end
            ACK1: begin
                if (cnt_last) begin
                    state_d = GAP1;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP1: begin
                if (cnt_last) begin
                    state_d = ACK2;
                    cnt_d   = PW_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK2: begin
                if (cnt_last) begin
                    // Only the second pulse carries the vector byte.
                    state_d  = HOLD;
                    vector_d = pic_data_bus;
                    error_d  = pic_data_bus_io;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_d     = RECOVER;
                    cnt_d       = REC_LOAD;
                    ack_count_d = ack_count_q + 16'd1;
                end
            end
            RECOVER: begin
                if (cnt_last) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs decode the next state so they come straight from flops.
        inta_n_d = !((state_d == ACK1) || (state_d == ACK2));
        valid_d  = (state_d == HOLD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            inta_n_q    <= 1'b1;
            valid_q     <= 1'b0;
            vector_q    <= 8'h00;
            error_q     <= 1'b0;
            ack_count_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            inta_n_q    <= inta_n_d;
            valid_q     <= valid_d;
            vector_q    <= vector_d;
            error_q     <= error_d;
            ack_count_q <= ack_count_d;
        end
    end

    assign interrupt_acknowledge_n = inta_n_q;
    assign vector_valid            = valid_q;
    assign vector                  = vector_q;
    assign vector_error            = error_q;
    assign ack_count               = ack_count_q;

endmodule
